// File: rtl/shift_unit_pipe_if.sv
// Valid/ready bundle for the pipelined shifter: operation
// request on the in_* side, tagged result on the out_* side.
interface shift_unit_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = 5,
  parameter int TAG_WIDTH  = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_op;
  logic [SHAMT_W-1:0]    in_shamt;
  logic [DATA_WIDTH-1:0] in_data;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;

  modport master (
    output in_valid, in_op, in_shamt, in_data, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_shamt, in_data, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROTR) with a tag
// sideband; the barrel levels are spread over STAGES registers.
module shift_unit_pipe #(
  parameter int DATA_WIDTH       = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_WIDTH        = 5
) (
  input logic clk,
  input logic reset,
  input logic flush,
  shift_unit_pipe_if.slave io
);
  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam int STAGES  =
    (SHAMT_W + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  logic advance;

  function automatic logic [DATA_WIDTH-1:0] level(
    input logic [1:0]            op,
    input logic [DATA_WIDTH-1:0] d,
    input int                    k
  );
    int unsigned           n;
    logic [DATA_WIDTH-1:0] r;
    n = 32'd1 << k;
    // SRA never changes the MSB, so it still equals the original sign
    unique case (op)
      2'b00:   r = d << n;
      2'b01:   r = d >> n;
      2'b10:   r = $signed(d) >>> n;
      default: r = (d >> n) | (d << (DATA_WIDTH - n));
    endcase
    return r;
  endfunction

  assign advance      = !g_st[STAGES-1].vld_q || io.out_ready;
  assign io.in_ready  = advance && !flush;
  assign io.out_valid = g_st[STAGES-1].vld_q;
  assign io.out_data  = g_st[STAGES-1].dat_q;
  assign io.out_tag   = g_st[STAGES-1].tag_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = s * LEVELS_PER_STAGE;
    localparam int HI =
      (LO + LEVELS_PER_STAGE < SHAMT_W) ?
      LO + LEVELS_PER_STAGE : SHAMT_W;

    logic                  v_in;
    logic [1:0]            op_in;
    logic [SHAMT_W-1:LO]   sh_in;
    logic [DATA_WIDTH-1:0] d_in;
    logic [TAG_WIDTH-1:0]  t_in;
    logic [DATA_WIDTH-1:0] d_nxt;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [TAG_WIDTH-1:0]  tag_q;

    if (s == 0) begin : g_src
      assign v_in  = io.in_valid && io.in_ready;
      assign op_in = io.in_op;
      assign sh_in = io.in_shamt;
      assign d_in  = io.in_data;
      assign t_in  = io.in_tag;
    end else begin : g_src
      assign v_in  = g_st[s-1].vld_q;
      assign op_in = g_st[s-1].g_ctl.op_q;
      assign sh_in = g_st[s-1].g_ctl.sh_q;
      assign d_in  = g_st[s-1].dat_q;
      assign t_in  = g_st[s-1].tag_q;
    end

    always_comb begin
      d_nxt = d_in;
      for (int k = LO; k < HI; k++) begin
        if (sh_in[k]) d_nxt = level(op_in, d_nxt, k);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q <= 1'b0;
        dat_q <= '0;
        tag_q <= '0;
      end else begin
        if (flush) vld_q <= 1'b0;
        else if (advance) vld_q <= v_in;
        if (advance) begin
          dat_q <= d_nxt;
          tag_q <= t_in;
        end
      end
    end

    // only the shamt bits later stages still consume travel on
    if (s < STAGES - 1) begin : g_ctl
      logic [1:0]          op_q;
      logic [SHAMT_W-1:HI] sh_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          op_q <= '0;
          sh_q <= '0;
        end else if (advance) begin
          op_q <= op_in;
          sh_q <= sh_in[SHAMT_W-1:HI];
        end
      end
    end
  end
endmodule

// File: tb/tb_shift_unit_pipe.sv
// Bench for shift_unit_pipe: scoreboard on the default config
// plus directed latency/reset checks on two other configs.
module tb_shift_unit_pipe;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic nofl = 1'b0;

  always #5 clk = ~clk;

  shift_unit_pipe_if #(.DATA_WIDTH(32), .SHAMT_W(5),
    .TAG_WIDTH(5)) im ();
  shift_unit_pipe_if #(.DATA_WIDTH(32), .SHAMT_W(5),
    .TAG_WIDTH(5)) ia ();
  shift_unit_pipe_if #(.DATA_WIDTH(16), .SHAMT_W(4),
    .TAG_WIDTH(5)) ib ();

  shift_unit_pipe #(.DATA_WIDTH(32), .LEVELS_PER_STAGE(2),
    .TAG_WIDTH(5)) um (
    .clk(clk), .reset(rst_n), .flush(flush), .io(im));
  shift_unit_pipe #(.DATA_WIDTH(32), .LEVELS_PER_STAGE(1),
    .TAG_WIDTH(5)) ua (
    .clk(clk), .reset(rst_n), .flush(nofl), .io(ia));
  shift_unit_pipe #(.DATA_WIDTH(16), .LEVELS_PER_STAGE(2),
    .TAG_WIDTH(5)) ub (
    .clk(clk), .reset(rst_n), .flush(nofl), .io(ib));

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [4:0]  hold_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // result bit i defined directly from the op semantics
  function automatic logic [31:0] model(input int w,
    input logic [1:0] op, input logic [31:0] d, input int sh);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (op)
        2'd0: r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        2'd1: r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
        2'd2: r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
        default: r[i] = d[(i+sh)%w];
      endcase
    end
    return r;
  endfunction

  always @(negedge rst_n) q.delete();

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (im.out_valid && im.out_ready) begin
        if (q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_out: got tag %0d want none",
                   im.out_tag);
        end else begin
          e = q.pop_front();
          chk("out_data", im.out_data, e.data);
          chk("out_tag", 32'(im.out_tag), 32'(e.tag));
        end
      end
      if (hold_v && im.out_valid) begin
        chk("stall_data", im.out_data, hold_d);
        chk("stall_tag", 32'(im.out_tag), 32'(hold_t));
      end
      hold_v = im.out_valid && !im.out_ready;
      hold_d = im.out_data;
      hold_t = im.out_tag;
      if (flush) q.delete();
      if (im.in_valid && im.in_ready) begin
        e.tag  = im.in_tag;
        e.data = model(32, im.in_op, im.in_data,
                       int'(im.in_shamt));
        q.push_back(e);
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_m(input logic [1:0] op,
    input logic [31:0] d, input logic [4:0] sh,
    input logic [4:0] tag);
    im.in_valid = 1'b1;
    im.in_op    = op;
    im.in_data  = d;
    im.in_shamt = sh;
    im.in_tag   = tag;
  endtask

  task automatic lat_m(input string nm, input logic [1:0] op,
    input logic [31:0] d, input logic [4:0] sh,
    input logic [4:0] tag, input logic [31:0] exp);
    int n;
    im.out_ready = 1'b1;
    drv_m(op, d, sh, tag);
    step();
    im.in_valid = 1'b0;
    n = 1;
    while (!im.out_valid && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'd3);
    chk({nm, "_data"}, im.out_data, exp);
    chk({nm, "_tag"}, 32'(im.out_tag), 32'(tag));
  endtask

  task automatic lat_a(input string nm, input logic [1:0] op,
    input logic [31:0] d, input logic [4:0] sh,
    input logic [31:0] exp);
    int n;
    ia.out_ready = 1'b1;
    ia.in_valid  = 1'b1;
    ia.in_op     = op;
    ia.in_data   = d;
    ia.in_shamt  = sh;
    ia.in_tag    = 5'd9;
    step();
    ia.in_valid = 1'b0;
    n = 1;
    while (!ia.out_valid && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'd5);
    chk({nm, "_data"}, ia.out_data, exp);
  endtask

  task automatic lat_b(input string nm, input logic [1:0] op,
    input logic [15:0] d, input logic [3:0] sh,
    input logic [15:0] exp);
    int n;
    ib.out_ready = 1'b1;
    ib.in_valid  = 1'b1;
    ib.in_op     = op;
    ib.in_data   = d;
    ib.in_shamt  = sh;
    ib.in_tag    = 5'd17;
    step();
    ib.in_valid = 1'b0;
    n = 1;
    while (!ib.out_valid && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'd2);
    chk({nm, "_data"}, 32'(ib.out_data), 32'(exp));
  endtask

  task automatic drain_m(input string nm);
    int g;
    g = 0;
    while ((q.size() != 0 || im.out_valid) && g < 60) begin
      step();
      g++;
    end
    chk(nm, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    im.in_valid = 1'b0; im.in_op = '0; im.in_shamt = '0;
    im.in_data = '0; im.in_tag = '0; im.out_ready = 1'b1;
    ia.in_valid = 1'b0; ia.in_op = '0; ia.in_shamt = '0;
    ia.in_data = '0; ia.in_tag = '0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_op = '0; ib.in_shamt = '0;
    ib.in_data = '0; ib.in_tag = '0; ib.out_ready = 1'b1;

    #12;
    chk("rst_ov", 32'(im.out_valid), 32'd0);
    chk("rst_data", im.out_data, 32'd0);
    chk("rst_tag", 32'(im.out_tag), 32'd0);
    chk("rst_ov_a", 32'(ia.out_valid), 32'd0);
    chk("rst_ov_b", 32'(ib.out_valid), 32'd0);

    chk("pin_sll31", model(32, 2'd0, 32'h1, 31), 32'h80000000);
    chk("pin_sll2", model(32, 2'd0, 32'h403, 2), 32'h100C);
    chk("pin_sra", model(32, 2'd2, 32'h80000000, 4),
        32'hF8000000);
    chk("pin_srl", model(32, 2'd1, 32'h80000000, 4),
        32'h08000000);
    chk("pin_rotr", model(32, 2'd3, 32'h12345678, 8),
        32'h78123456);
    chk("pin_sra16", model(16, 2'd2, 32'h8000, 4), 32'hF800);
    chk("pin_rotr16", model(16, 2'd3, 32'h1234, 8), 32'h3412);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(im.in_ready), 32'd1);
    step();

    lat_m("sll31", 2'd0, 32'h00000001, 5'd31, 5'd1, 32'h80000000);
    lat_m("sll2", 2'd0, 32'h00000403, 5'd2, 5'd2, 32'h0000100C);
    lat_m("sra4", 2'd2, 32'h80000000, 5'd4, 5'd3, 32'hF8000000);
    lat_m("srl4", 2'd1, 32'h80000000, 5'd4, 5'd4, 32'h08000000);
    lat_m("sra0", 2'd2, 32'h80000000, 5'd0, 5'd5, 32'h80000000);
    lat_m("srl0", 2'd1, 32'h80000000, 5'd0, 5'd6, 32'h80000000);
    lat_m("rotr8", 2'd3, 32'h12345678, 5'd8, 5'd7, 32'h78123456);
    lat_m("rotr1", 2'd3, 32'h00000001, 5'd1, 5'd8, 32'h80000000);
    step();

    fork
      begin
        int acc;
        int g;
        for (int i = 0; i < 10; i++) begin
          drv_m(2'(i % 4), 32'h9E3779B9 * 32'(i + 1),
                5'((i * 7) % 32), 5'(i));
          acc = 0;
          g = 0;
          while (acc == 0 && g < 50) begin
            @(negedge clk);
            acc = int'(im.in_ready);
            step();
            g++;
          end
          if (acc == 0) chk("stream_accept", 32'd0, 32'd1);
        end
        im.in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        im.out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(im.in_ready), 32'd0);
          chk("stall_ov", 32'(im.out_valid), 32'd1);
        end
        step();
        im.out_ready = 1'b1;
      end
    join
    drain_m("stream_drain");
    step();

    for (int i = 0; i < 3; i++) begin
      drv_m(2'd1, 32'hAAAA0000 + 32'(i), 5'd3, 5'(20 + i));
      step();
    end
    im.out_ready = 1'b0;
    drv_m(2'd0, 32'h5, 5'd1, 5'd23);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(im.in_ready), 32'd0);
    step();
    flush = 1'b0;
    im.in_valid = 1'b0;
    chk("flush_ov", 32'(im.out_valid), 32'd0);
    lat_m("post_flush", 2'd2, 32'h80000010, 5'd2, 5'd27,
          32'hE0000004);
    drain_m("flush_drain");
    step();

    im.out_ready = 1'b0;
    ia.out_ready = 1'b0;
    ib.out_ready = 1'b0;
    drv_m(2'd0, 32'h11, 5'd1, 5'd24);
    ia.in_valid = 1'b1; ia.in_data = 32'hFFFF; ia.in_shamt = 5'd4;
    ia.in_op = 2'd0; ia.in_tag = 5'd3;
    ib.in_valid = 1'b1; ib.in_data = 16'h00FF; ib.in_shamt = 4'd4;
    ib.in_op = 2'd0; ib.in_tag = 5'd3;
    step();
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
    drv_m(2'd0, 32'h22, 5'd1, 5'd25);
    step();
    drv_m(2'd0, 32'h33, 5'd1, 5'd26);
    step();
    im.in_valid = 1'b0;
    repeat (3) step();
    chk("pre_rst_ov", 32'(im.out_valid), 32'd1);
    chk("pre_rst_ov_a", 32'(ia.out_valid), 32'd1);
    chk("pre_rst_ov_b", 32'(ib.out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(im.out_valid), 32'd0);
    chk("arst_data", im.out_data, 32'd0);
    chk("arst_tag", 32'(im.out_tag), 32'd0);
    chk("arst_ov_a", 32'(ia.out_valid), 32'd0);
    chk("arst_data_a", ia.out_data, 32'd0);
    chk("arst_ov_b", 32'(ib.out_valid), 32'd0);
    chk("arst_data_b", 32'(ib.out_data), 32'd0);
    #1;
    rst_n = 1'b1;
    im.out_ready = 1'b1;
    ia.out_ready = 1'b1;
    ib.out_ready = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(im.in_ready), 32'd1);
    lat_m("post_rst", 2'd3, 32'h0000ABCD, 5'd16, 5'd30,
          32'hABCD0000);

    lat_a("a_sll31", 2'd0, 32'h00000001, 5'd31, 32'h80000000);
    lat_a("a_sra4", 2'd2, 32'h80000000, 5'd4, 32'hF8000000);
    lat_a("a_rotr8", 2'd3, 32'h12345678, 5'd8, 32'h78123456);
    lat_b("b_sra4", 2'd2, 16'h8000, 4'd4, 16'hF800);
    lat_b("b_rotr8", 2'd3, 16'h1234, 4'd8, 16'h3412);
    lat_b("b_srl15", 2'd1, 16'h8000, 4'd15, 16'h0001);
    lat_b("b_sll0", 2'd0, 16'hBEEF, 4'd0, 16'hBEEF);

    drain_m("final_drain");
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule

// File: doc/shift_unit_pipe.md
# shift_unit_pipe

Parametrised, pipelined barrel shifter for the pipelined MIPS datapath. It performs SLL, SRL, SRA and ROTR on a DATA_WIDTH operand by a variable amount. The shift network is split into register stages so that it meets timing at the core clock, and it carries a tag (destination register) alongside each operation. It sits between the ID/EX operand muxes and the EX/MEM writeback path. It also covers the fixed shift-by-2 used for branch offsets: issue SLL with shamt = 2.

## Interface

Parameters:
- DATA_WIDTH, 32: operand/result width; a power of two, at least 4.
- LEVELS_PER_STAGE, 2: barrel levels evaluated per register stage; range 1 to SHAMT_W.
- TAG_WIDTH, 5: width of the sideband tag carried with each operation.
- Derived, not overridable:
  - SHAMT_W = clog2(DATA_WIDTH).
  - STAGES = ceil(SHAMT_W / LEVELS_PER_STAGE). Defaults give 3.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous pipeline kill.
- in_valid, input, 1: an operation is presented.
- in_ready, output, 1: the unit accepts the operation this cycle.
- in_op, input, 2: operation code. 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROTR.
- in_shamt, input, SHAMT_W: shift amount.
- in_data, input, DATA_WIDTH: operand.
- in_tag, input, TAG_WIDTH: sideband tag, passed through unchanged.
- out_valid, output, 1: result available.
- out_ready, input, 1: downstream consumes the result.
- out_data, output, DATA_WIDTH: result.
- out_tag, output, TAG_WIDTH: tag of the operation in out_data.

## Operation

- The barrel is built from SHAMT_W levels. Level k shifts by 2^k when in_shamt[k] = 1.
- Levels are evaluated in ascending k. Stage s holds levels s·LEVELS_PER_STAGE through min((s+1)·LEVELS_PER_STAGE, SHAMT_W)−1.
- Each stage register holds: valid, op, the remaining shamt bits, partial data and tag.
- Per-level fill rules:
  - SLL: shift left, zero fill.
  - SRL: shift right, zero fill.
  - SRA: shift right, fill with the operand's original bit DATA_WIDTH−1.
  - ROTR: rotate right; bits leaving the LSB enter at the MSB.
- The shift amount is naturally modulo DATA_WIDTH, since no wider amount can be expressed. shamt = 0 passes the data through unchanged for every op.
- Stage control:
  - Global advance = !out_valid || out_ready.
  - When advance = 1, every stage loads from its predecessor, and stage 0 loads from the inputs.
  - When advance = 0, every stage holds.
- Bubbles propagate: a stage that loads from an invalid predecessor becomes invalid.
- Acceptance:
  - in_ready = advance && !flush.
  - An operation is accepted on a cycle with in_valid && in_ready.
- Flush:
  - At the clock edge, all stage valid bits clear.
  - The input presented that cycle is not accepted.
  - Flush overrides stall.
- Ordering: results leave strictly in acceptance order. No result is dropped or duplicated except by flush or reset.
- Datapath registers (data, tag, op, shamt) do not need clearing on a flush. Only the valid bits are cleared.

## Timing

- Latency is STAGES cycles (3 at defaults). An operation accepted at edge N shows out_valid = 1 after edge N+STAGES−1, provided no stall occurs.
- Throughput is one operation per cycle while out_ready = 1.
- Each cycle of out_ready = 0 while out_valid = 1 adds exactly one cycle of latency to every in-flight operation.
- out_data and out_tag are registered, and remain stable while out_valid && !out_ready.
- Reset (reset = 0), asynchronous and immediate:
  - All stage valid bits are 0, so out_valid = 0.
  - out_data = 0 and out_tag = 0.
  - in_ready = 1 once reset deasserts.
- Reset during operation discards all in-flight operations. The first accepted operation after reset deassertion behaves as if the pipeline were empty.
- Flush and out_ready on the same cycle: the result on the output counts as consumed, and the pipeline is still cleared.

## Test plan

- **SLL:** in_data = 0x00000001, shamt = 31 → out_data = 0x80000000 after 3 cycles. Also in_data = 0x00000403, shamt = 2 → 0x0000100C.
- **SRA vs SRL:** in_data = 0x80000000, shamt = 4.
  - SRA → 0xF8000000.
  - SRL → 0x08000000.
  - shamt = 0 → 0x80000000 for both.
- **ROTR:** 0x12345678 by 8 → 0x78123456. 0x00000001 by 1 → 0x80000000.
- **Streaming under backpressure:** 10 back-to-back ops with tags 0–9. Hold out_ready = 0 for 4 cycles mid-stream. Required:
  - in_ready falls in the same cycle as advance.
  - All 10 results arrive in tag order with correct data.
  - out_data stays stable while stalled.
- **Flush:** 3 ops in flight, then assert flush with in_valid = 1. Required:
  - out_valid = 0 from the next cycle.
  - None of the 4 operations ever emerges.
  - An op issued on the next cycle emerges 3 cycles later.
- **Reset during operation:** pull reset low between clock edges with the pipe full. Required:
  - out_valid, out_data and out_tag go to 0 before the next edge.
  - After release, correct operation resumes with 3-cycle latency.
  - Repeat with LEVELS_PER_STAGE = 1 (latency 5) and DATA_WIDTH = 16.
